// File: rtl/script_loader_pkg.sv
// Shared constants for the script loader: frame marker, safe end-game word and loader state encodings.
package script_loader_pkg;

    localparam int          DEPTH       = 256;
    localparam int          AW          = 8;
    localparam int          TIMEOUT_DEF = 1_000_000;
    localparam logic [7:0]  HDR         = 8'hA5;
    localparam logic [15:0] END_WORD    = 16'h0014;

    typedef enum logic [7:0] {
        ST_IDLE = 8'h00,
        ST_LEN  = 8'h01,
        ST_DATA = 8'h02,
        ST_CSUM = 8'h03,
        ST_ERR  = 8'h04
    } loader_state_e;

    // An instruction byte address is served only below 2*count; 9-bit compare covers count==128.
    function automatic logic pcInRange(input logic [AW-1:0] pc, input logic [7:0] cnt);
        return {1'b0, pc} < {cnt, 1'b0};
    endfunction

endpackage

// File: rtl/script_loader_ram.sv
// Script byte RAM: one synchronous write port and a registered 16-bit read of {mem[a+1], mem[a]}.
module script_loader_ram
    import script_loader_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] raddr_i,
    output logic [15:0]   rdata_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [15:0]   rdata_q;
    logic [AW-1:0] raddr_hi_d;

    assign raddr_hi_d = raddr_i + AW'(1);

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Disabled reads return the end-game word so the controller stops safely.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rdata_q <= END_WORD;
        end else if (rd_en_i) begin
            rdata_q <= {mem_q[raddr_hi_d], mem_q[raddr_i]};
        end else begin
            rdata_q <= END_WORD;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/script_loader.sv
// Receives HDR/N/data/CSUM frames from the UART byte stream into the script RAM and serves instructions at pc.
module script_loader
    import script_loader_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
)
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_valid_i,
    input  logic [AW-1:0] pc_i,
    output logic [15:0]   script_o,
    output logic          loaded_o,
    output logic          busy_o,
    output logic          load_err_o,
    output logic [7:0]    instr_cnt_o
);

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);
    localparam logic [7:0]  MAX_N    = 8'(DEPTH / 2);

    loader_state_e state_q;
    logic [7:0]    n_q;
    logic [7:0]    xor_q;
    logic [AW-1:0] wr_addr_q;
    logic [31:0]   tmo_q;
    logic          loaded_q;
    logic          busy_q;
    logic          load_err_q;
    logic [7:0]    instr_cnt_q;

    logic [AW-1:0] last_addr_d;
    logic          we_d;
    logic          rd_en_d;

    assign last_addr_d = AW'({n_q, 1'b0} - 9'd1);
    assign we_d        = (state_q == ST_DATA) && rx_valid_i;
    assign rd_en_d     = loaded_q && !busy_q && pcInRange(pc_i, instr_cnt_q);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            xor_q       <= '0;
            wr_addr_q   <= '0;
            tmo_q       <= '0;
            loaded_q    <= 1'b0;
            busy_q      <= 1'b0;
            load_err_q  <= 1'b0;
            instr_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid_i && rx_data_i == HDR) begin
                        state_q    <= ST_LEN;
                        loaded_q   <= 1'b0;
                        load_err_q <= 1'b0;
                        busy_q     <= 1'b1;
                        xor_q      <= '0;
                        tmo_q      <= '0;
                    end
                end
                ST_LEN, ST_DATA, ST_CSUM: begin
                    // A byte arriving on the timeout cycle takes priority and restarts the gap counter.
                    if (rx_valid_i) begin
                        tmo_q <= '0;
                        case (state_q)
                            ST_LEN: begin
                                n_q   <= rx_data_i;
                                xor_q <= rx_data_i;
                                if (rx_data_i > MAX_N) begin
                                    state_q <= ST_ERR;
                                    busy_q  <= 1'b0;
                                end else if (rx_data_i == 8'd0) begin
                                    state_q <= ST_CSUM;
                                end else begin
                                    state_q   <= ST_DATA;
                                    wr_addr_q <= '0;
                                end
                            end
                            ST_DATA: begin
                                xor_q     <= xor_q ^ rx_data_i;
                                wr_addr_q <= wr_addr_q + AW'(1);
                                if (wr_addr_q == last_addr_d) begin
                                    state_q <= ST_CSUM;
                                end
                            end
                            default: begin
                                busy_q <= 1'b0;
                                if (rx_data_i == xor_q) begin
                                    state_q     <= ST_IDLE;
                                    instr_cnt_q <= n_q;
                                    loaded_q    <= 1'b1;
                                end else begin
                                    state_q <= ST_ERR;
                                end
                            end
                        endcase
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= ST_ERR;
                        busy_q  <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                ST_ERR: begin
                    state_q     <= ST_IDLE;
                    load_err_q  <= 1'b1;
                    instr_cnt_q <= '0;
                    loaded_q    <= 1'b0;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    script_loader_ram u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (we_d),
        .waddr_i (wr_addr_q),
        .wdata_i (rx_data_i),
        .rd_en_i (rd_en_d),
        .raddr_i (pc_i),
        .rdata_o (script_o)
    );

    assign loaded_o    = loaded_q;
    assign busy_o      = busy_q;
    assign load_err_o  = load_err_q;
    assign instr_cnt_o = instr_cnt_q;

endmodule
